// File: rtl/multdiv_issue_ctrl_if.sv
// Bus bundle between the pipeline/multdiv side (master) and the
// multdiv issue controller (slave). It covers the issue request, the
// multdiv operand/control/result lines and the writeback handshake.
interface multdiv_issue_ctrl_if #(
    parameter int unsigned RD_WIDTH = 5
);
    localparam int unsigned DATA_W = 32;

    // Issue side
    logic                issue_valid;
    logic                issue_op;
    logic [RD_WIDTH-1:0] issue_rd;
    logic [DATA_W-1:0]   operand_a;
    logic [DATA_W-1:0]   operand_b;
    logic                issue_ready;

    // Multdiv side
    logic [DATA_W-1:0]   md_operandA;
    logic [DATA_W-1:0]   md_operandB;
    logic                md_ctrl_MULT;
    logic                md_ctrl_DIV;
    logic [DATA_W-1:0]   md_result;
    logic                md_exception;
    logic                md_resultRDY;

    // Writeback side
    logic                wb_valid;
    logic                wb_ready;
    logic [RD_WIDTH-1:0] wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic                wb_exception;

    // Pipeline, multdiv unit and writeback stage as seen from outside
    modport master (
        output issue_valid, issue_op, issue_rd, operand_a, operand_b,
        input  issue_ready,
        input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        output md_result, md_exception, md_resultRDY,
        input  wb_valid, wb_rd, wb_data, wb_exception,
        output wb_ready
    );

    // The issue controller
    modport slave (
        input  issue_valid, issue_op, issue_rd, operand_a, operand_b,
        output issue_ready,
        output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        input  md_result, md_exception, md_resultRDY,
        output wb_valid, wb_rd, wb_data, wb_exception,
        input  wb_ready
    );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Multdiv issue controller: accepts one MULT/DIV request at a time, holds
// the operands on the multdiv inputs, pulses the matching ctrl line for a
// single cycle, waits for data_resultRDY and hands the captured result to
// writeback with a valid/ready handshake. flush aborts the op in flight.
// Optional watchdog: define MULTDIV_TIMEOUT_EN to end a BUSY phase that
// sees no md_resultRDY within TIMEOUT_CYCLES cycles with wb_data=0 and
// wb_exception=1. Without the macro BUSY waits indefinitely.
module multdiv_issue_ctrl #(
    parameter int unsigned RD_WIDTH = 5
`ifdef MULTDIV_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 40
`endif
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    multdiv_issue_ctrl_if.slave  bus
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q,       state_d;
    logic                issue_ready_q, issue_ready_d;
    logic                ctrl_mult_q,   ctrl_mult_d;
    logic                ctrl_div_q,    ctrl_div_d;
    logic [DATA_W-1:0]   opa_q,         opa_d;
    logic [DATA_W-1:0]   opb_q,         opb_d;
    logic [RD_WIDTH-1:0] rd_q,          rd_d;
    logic                wb_valid_q,    wb_valid_d;
    logic [DATA_W-1:0]   wb_data_q,     wb_data_d;
    logic                wb_exc_q,      wb_exc_d;
    logic                timeout_c;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // BUSY-cycle counter: cleared on the way into BUSY, counts while in BUSY
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == START) begin
            cnt_d = '0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry in the last allowed BUSY cycle; a ready in that same cycle wins
    assign timeout_c = (cnt_q == CNT_LAST);
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        issue_ready_d = issue_ready_q;
        ctrl_mult_d   = 1'b0;
        ctrl_div_d    = 1'b0;
        opa_d         = opa_q;
        opb_d         = opb_q;
        rd_d          = rd_q;
        wb_valid_d    = wb_valid_q;
        wb_data_d     = wb_data_q;
        wb_exc_d      = wb_exc_q;

        unique case (state_q)
            IDLE: begin
                if (bus.issue_valid && !flush) begin
                    opa_d         = bus.operand_a;
                    opb_d         = bus.operand_b;
                    rd_d          = bus.issue_rd;
                    ctrl_mult_d   = !bus.issue_op;
                    ctrl_div_d    = bus.issue_op;
                    issue_ready_d = 1'b0;
                    state_d       = START;
                end
            end

            // The ctrl pulse is visible this cycle; any ready now is stale
            START: begin
                state_d = BUSY;
            end

            BUSY: begin
                if (bus.md_resultRDY) begin
                    wb_data_d  = bus.md_result;
                    wb_exc_d   = bus.md_exception;
                    wb_valid_d = 1'b1;
                    state_d    = DONE;
                end else if (timeout_c) begin
                    wb_data_d  = '0;
                    wb_exc_d   = 1'b1;
                    wb_valid_d = 1'b1;
                    state_d    = DONE;
                end
            end

            // Result is held until writeback takes it; one bubble before IDLE
            DONE: begin
                if (bus.wb_ready) begin
                    wb_valid_d    = 1'b0;
                    issue_ready_d = 1'b1;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d       = IDLE;
                wb_valid_d    = 1'b0;
                issue_ready_d = 1'b1;
            end
        endcase

        // Abort wins over issue and writeback; the flushed op is never reported
        if (flush) begin
            state_d       = IDLE;
            issue_ready_d = 1'b1;
            wb_valid_d    = 1'b0;
            ctrl_mult_d   = 1'b0;
            ctrl_div_d    = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            issue_ready_q <= 1'b1;
            ctrl_mult_q   <= 1'b0;
            ctrl_div_q    <= 1'b0;
            opa_q         <= '0;
            opb_q         <= '0;
            rd_q          <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_exc_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_ready_q <= issue_ready_d;
            ctrl_mult_q   <= ctrl_mult_d;
            ctrl_div_q    <= ctrl_div_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            rd_q          <= rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_exc_q      <= wb_exc_d;
        end
    end

    assign bus.issue_ready  = issue_ready_q;
    assign bus.md_operandA  = opa_q;
    assign bus.md_operandB  = opb_q;
    assign bus.md_ctrl_MULT = ctrl_mult_q;
    assign bus.md_ctrl_DIV  = ctrl_div_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_exception = wb_exc_q;

    // Structural invariants of the controller
    a_ctrl_onehot : assert property (@(posedge clock) disable iff (!reset_n)
        !(ctrl_mult_q && ctrl_div_q));
    a_ctrl_in_start : assert property (@(posedge clock) disable iff (!reset_n)
        (ctrl_mult_q || ctrl_div_q) |-> (state_q == START));
    a_ready_in_idle : assert property (@(posedge clock) disable iff (!reset_n)
        issue_ready_q == (state_q == IDLE));
    a_valid_in_done : assert property (@(posedge clock) disable iff (!reset_n)
        wb_valid_q == (state_q == DONE));

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
Initiator-side controller that drives the multdiv unit from the processor pipeline. It accepts a MULT or DIV request, holds the operands stable, and pulses ctrl_MULT or ctrl_DIV for exactly one cycle. It then stalls issue until data_resultRDY and presents the captured result/exception to writeback with a valid/ready handshake. It sits between decode/execute and the multdiv instance; one operation is in flight at a time.

Parameters:
RD_WIDTH, 5, width of destination register tag carried with the op
TIMEOUT_CYCLES, 40, BUSY cycles without md_resultRDY before the watchdog fires (only with MULTDIV_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
issue_valid  in  1  request present
issue_op  in  1  0 = multiply, 1 = divide
issue_rd  in  RD_WIDTH  destination register tag
operand_a  in  32  first operand (multiplicand / dividend)
operand_b  in  32  second operand (multiplier / divisor)
issue_ready  out  1  controller can accept; low = pipeline stall
flush  in  1  synchronous abort of the current op
md_operandA  out  32  to multdiv data_operandA
md_operandB  out  32  to multdiv data_operandB
md_ctrl_MULT  out  1  to multdiv ctrl_MULT
md_ctrl_DIV  out  1  to multdiv ctrl_DIV
md_result  in  32  from multdiv data_result
md_exception  in  1  from multdiv data_exception
md_resultRDY  in  1  from multdiv data_resultRDY
wb_valid  out  1  result available
wb_ready  in  1  writeback consumes result
wb_rd  out  RD_WIDTH  tag of the completed op
wb_data  out  32  result
wb_exception  out  1  overflow / divide-by-zero / timeout

Behaviour:
- Reset (reset_n low, async): state IDLE; issue_ready=1; md_ctrl_MULT=md_ctrl_DIV=0; md_operandA/B=0; wb_valid=0; wb_data=0; wb_rd=0; wb_exception=0; op register=0; timeout counter=0.
- States: IDLE, START, BUSY, DONE. issue_ready=1 only in IDLE.
- IDLE: when issue_valid=1 and flush=0, register operand_a/b onto md_operandA/B and register issue_op and issue_rd -> START.
- START: assert exactly one of md_ctrl_MULT (op=0) or md_ctrl_DIV (op=1) for this single cycle -> BUSY. Ctrl outputs are registered; both are never high together.
- BUSY: md_resultRDY is sampled only here, so a stale ready during the START cycle is ignored. On md_resultRDY=1, capture wb_data=md_result and wb_exception=md_exception -> DONE.
- DONE: wb_valid=1; wb_data, wb_rd and wb_exception are held stable. On wb_ready=1 -> IDLE. No issue is accepted in the same cycle; there is one bubble.
- md_operandA/B are held from the capture until the next accepted issue, so they remain stable for the whole operation.
- Latency: issue accepted at edge T; ctrl pulse during cycle T+1; BUSY from T+2; md_resultRDY seen in cycle R; wb_valid high from R+1.
- flush=1 in any state -> IDLE next edge, with wb_valid=0 and ctrl outputs 0. It overrides issue_valid in IDLE and wb_ready in DONE. A flushed op is never reported; multdiv may keep running, and the next ctrl pulse restarts it.
- flush during START: the ctrl pulse still completes that cycle (registered); the result is discarded.
- Async reset mid-operation: as reset; the in-flight result is discarded.
- No arithmetic in this block; the data path is 32-bit pass-through.

Optional Feature:
MULTDIV_TIMEOUT_EN:
- Defined: a counter of width clog2(TIMEOUT_CYCLES+1) is cleared on entering BUSY and increments each BUSY cycle. If it reaches TIMEOUT_CYCLES with md_resultRDY still 0, the controller goes to DONE with wb_data=0 and wb_exception=1. md_resultRDY in the same cycle as expiry wins: the normal result is captured.
- Not defined: the counter is absent, and BUSY waits indefinitely.

Test Plan:
- Reset, then issue_op=0, A=6, B=7, rd=3 with real multdiv -> one-cycle md_ctrl_MULT pulse at T+1, issue_ready low until DONE, then wb_valid with wb_data=42, wb_rd=3, wb_exception=0.
- issue_op=1, A=100, B=7 -> one md_ctrl_DIV pulse, wb_data=14, wb_exception=0; then issue A=-20, B=3 -> wb_data=-6 (0xFFFFFFFA).
- DIV A=5, B=0 -> wb_exception=1 passed through; wb_ready held low 5 cycles -> wb_valid, wb_data and wb_exception stay constant; consumed on wb_ready=1, back to IDLE the next cycle.
- MULT issued, flush asserted 3 cycles into BUSY -> IDLE next edge, no wb_valid ever for that op; following MULT 0x10000*0x10000 -> wb_exception=1 (overflow).
- Stub responder drives md_resultRDY=1 during the START cycle -> ignored, the controller remains in BUSY; a later real ready completes normally. Also drop reset_n mid-BUSY -> all outputs return to reset values immediately.
- With MULTDIV_TIMEOUT_EN, stub never asserts ready -> after 40 BUSY cycles wb_valid=1, wb_data=0, wb_exception=1; ready arriving at cycle 40 -> the real result is captured.
